// File: rtl/glitch_filter.sv
// Debounce filter for an asynchronous, possibly glitchy level: two-flop synchronizer,
// 4-state acceptance FSM, registered edge/glitch pulses and a saturating rise counter.
module glitch_filter #(
    parameter int STABLE_CNT = 4,
    parameter int CNT_W      = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in,
    input  logic             clr_cnt,
    output logic             filt_out,
    output logic             rise,
    output logic             fall,
    output logic             glitch,
    output logic [CNT_W-1:0] pulse_cnt
);

    localparam logic [1:0] STABLE_LO = 2'd0;
    localparam logic [1:0] CHK_HI    = 2'd1;
    localparam logic [1:0] STABLE_HI = 2'd2;
    localparam logic [1:0] CHK_LO    = 2'd3;

    localparam logic [3:0]       STABLE_N = 4'(STABLE_CNT);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == CNT_MAX) begin
            r = CNT_MAX;
        end else begin
            r = v + CNT_ONE;
        end
        return r;
    endfunction

    logic             sync1_r;
    logic             sync2_r;
    logic [1:0]       state_r;
    logic [1:0]       state_s;
    logic [3:0]       run_r;
    logic [3:0]       run_s;
    logic             rise_s;
    logic             fall_s;
    logic             glitch_s;
    logic             rise_p_r;
    logic             fall_p_r;
    logic             glitch_p_r;
    logic             filt_r;
    logic             rise_r;
    logic             fall_r;
    logic             glitch_r;
    logic [CNT_W-1:0] pulse_cnt_r;

    // Next-state logic: run counter tracks consecutive cycles sync2 disagrees with the accepted level
    always_comb begin
        state_s  = state_r;
        run_s    = run_r;
        rise_s   = 1'b0;
        fall_s   = 1'b0;
        glitch_s = 1'b0;
        case (state_r)
            STABLE_LO: begin
                if (sync2_r) begin
                    if (STABLE_N == 4'd1) begin
                        state_s = STABLE_HI;
                        run_s   = 4'd0;
                        rise_s  = 1'b1;
                    end else begin
                        state_s = CHK_HI;
                        run_s   = 4'd1;
                    end
                end else begin
                    run_s = 4'd0;
                end
            end
            CHK_HI: begin
                if (sync2_r) begin
                    if ((run_r + 4'd1) == STABLE_N) begin
                        state_s = STABLE_HI;
                        run_s   = 4'd0;
                        rise_s  = 1'b1;
                    end else begin
                        run_s = run_r + 4'd1;
                    end
                end else begin
                    state_s  = STABLE_LO;
                    run_s    = 4'd0;
                    glitch_s = 1'b1;
                end
            end
            STABLE_HI: begin
                if (!sync2_r) begin
                    if (STABLE_N == 4'd1) begin
                        state_s = STABLE_LO;
                        run_s   = 4'd0;
                        fall_s  = 1'b1;
                    end else begin
                        state_s = CHK_LO;
                        run_s   = 4'd1;
                    end
                end else begin
                    run_s = 4'd0;
                end
            end
            CHK_LO: begin
                if (!sync2_r) begin
                    if ((run_r + 4'd1) == STABLE_N) begin
                        state_s = STABLE_LO;
                        run_s   = 4'd0;
                        fall_s  = 1'b1;
                    end else begin
                        run_s = run_r + 4'd1;
                    end
                end else begin
                    state_s  = STABLE_HI;
                    run_s    = 4'd0;
                    glitch_s = 1'b1;
                end
            end
            default: begin
                state_s = STABLE_LO;
                run_s   = 4'd0;
            end
        endcase
    end

    // Synchronizer, FSM state and pending event flags
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_r    <= 1'b0;
            sync2_r    <= 1'b0;
            state_r    <= STABLE_LO;
            run_r      <= 4'd0;
            rise_p_r   <= 1'b0;
            fall_p_r   <= 1'b0;
            glitch_p_r <= 1'b0;
        end else begin
            sync1_r    <= in;
            sync2_r    <= sync1_r;
            state_r    <= state_s;
            run_r      <= run_s;
            rise_p_r   <= rise_s;
            fall_p_r   <= fall_s;
            glitch_p_r <= glitch_s;
        end
    end

    // Output stage: level and pulses are registered together so filt_out and its edge pulse align
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            filt_r   <= 1'b0;
            rise_r   <= 1'b0;
            fall_r   <= 1'b0;
            glitch_r <= 1'b0;
        end else begin
            filt_r   <= (state_r == STABLE_HI) || (state_r == CHK_LO);
            rise_r   <= rise_p_r;
            fall_r   <= fall_p_r;
            glitch_r <= glitch_p_r;
        end
    end

    // Rise counter: a clear landing on the same edge as a rise still counts that rise
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pulse_cnt_r <= {CNT_W{1'b0}};
        end else if (rise_p_r) begin
            pulse_cnt_r <= clr_cnt ? CNT_ONE : sat_inc(pulse_cnt_r);
        end else if (clr_cnt) begin
            pulse_cnt_r <= {CNT_W{1'b0}};
        end else begin
            pulse_cnt_r <= pulse_cnt_r;
        end
    end

    assign filt_out  = filt_r;
    assign rise      = rise_r;
    assign fall      = fall_r;
    assign glitch    = glitch_r;
    assign pulse_cnt = pulse_cnt_r;

endmodule

// File: tb/tb_glitch_filter.sv
// Randomized and directed bench for glitch_filter; a run-length reference model over the
// sampled input feeds a scoreboard that a negedge monitor drains and compares.
module tb_glitch_filter;

    localparam int N  = 4;
    localparam int CW = 8;

    logic          clock   = 1'b0;
    logic          reset_n = 1'b1;
    logic          in      = 1'b0;
    logic          clr_cnt = 1'b0;
    logic          filt_out;
    logic          rise;
    logic          fall;
    logic          glitch;
    logic [CW-1:0] pulse_cnt;

    glitch_filter #(.STABLE_CNT(N), .CNT_W(CW)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in        (in),
        .clr_cnt   (clr_cnt),
        .filt_out  (filt_out),
        .rise      (rise),
        .fall      (fall),
        .glitch    (glitch),
        .pulse_cnt (pulse_cnt)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit filt;
        bit rise;
        bit fall;
        bit glitch;
        int pcnt;
    } exp_t;

    exp_t pipe[$];
    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    bit   m_lvl;
    int   m_run;
    int   m_pcnt;

    function automatic exp_t idle(bit l);
        exp_t e;
        e.filt   = l;
        e.rise   = 1'b0;
        e.fall   = 1'b0;
        e.glitch = 1'b0;
        e.pcnt   = 0;
        return e;
    endfunction

    task automatic model_reset();
        m_lvl  = 1'b0;
        m_run  = 0;
        m_pcnt = 0;
        pipe.delete();
        sb.delete();
        // outputs trail the input sample by three edges (two sync flops + output register)
        repeat (3) pipe.push_back(idle(1'b0));
    endtask

    task automatic check(string name, int got, int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    // Reference model: a new level is accepted after N consecutive differing samples
    initial begin
        exp_t e;
        exp_t cur;
        model_reset();
        forever begin
            @(posedge clock or negedge reset_n);
            if (!reset_n) begin
                model_reset();
            end else begin
                e = idle(m_lvl);
                if (in !== m_lvl) begin
                    m_run++;
                    if (m_run >= N) begin
                        m_lvl  = !m_lvl;
                        m_run  = 0;
                        e.rise = m_lvl;
                        e.fall = !m_lvl;
                    end
                end else begin
                    if (m_run > 0) e.glitch = 1'b1;
                    m_run = 0;
                end
                e.filt = m_lvl;
                pipe.push_back(e);
                cur = pipe.pop_front();
                if (cur.rise) m_pcnt = clr_cnt ? 1 : ((m_pcnt < 255) ? m_pcnt + 1 : 255);
                else if (clr_cnt) m_pcnt = 0;
                cur.pcnt = m_pcnt;
                sb.push_back(cur);
            end
        end
    end

    // Monitor: compare each cycle's outputs against the scoreboard head
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (reset_n && sb.size() > 0) begin
                e = sb.pop_front();
                vectors++;
                if (filt_out !== e.filt || rise !== e.rise || fall !== e.fall ||
                    glitch !== e.glitch || pulse_cnt !== e.pcnt[7:0]) begin
                    miscompares++;
                    $display("FAIL outputs t=%0t: got filt=%b rise=%b fall=%b glitch=%b cnt=%0d, required filt=%b rise=%b fall=%b glitch=%b cnt=%0d",
                             $time, filt_out, rise, fall, glitch, pulse_cnt,
                             e.filt, e.rise, e.fall, e.glitch, e.pcnt);
                end
                vectors++;
                if (int'(rise) + int'(fall) + int'(glitch) > 1) begin
                    miscompares++;
                    $display("FAIL exclusive t=%0t: got rise=%b fall=%b glitch=%b, required at most one high",
                             $time, rise, fall, glitch);
                end
            end
        end
    end

    task automatic check_all_zero(string tag);
        check({tag, " filt_out"}, int'(filt_out), 0);
        check({tag, " rise"}, int'(rise), 0);
        check({tag, " fall"}, int'(fall), 0);
        check({tag, " glitch"}, int'(glitch), 0);
        check({tag, " pulse_cnt"}, int'(pulse_cnt), 0);
    endtask

    initial begin
        #1 reset_n = 1'b0;
        #1 check_all_zero("reset");
        repeat (3) @(negedge clock);
        #2 reset_n = 1'b1;

        // clean 0->1
        @(negedge clock); in = 1'b1;
        repeat (10) @(negedge clock);
        check("rise filt_out", int'(filt_out), 1);
        check("rise pulse_cnt", int'(pulse_cnt), 1);

        // sub-cycle low between edges, then one captured across an edge, then a 2-cycle low
        @(posedge clock); #1 in = 1'b0; #5 in = 1'b1;
        repeat (6) @(negedge clock);
        @(negedge clock); #1 in = 1'b0; #5 in = 1'b1;
        repeat (8) @(negedge clock);
        in = 1'b0;
        repeat (2) @(negedge clock);
        in = 1'b1;
        repeat (8) @(negedge clock);
        check("glitch filt_out held", int'(filt_out), 1);

        // clean 1->0
        in = 1'b0;
        repeat (8) @(negedge clock);
        check("fall filt_out", int'(filt_out), 0);
        check("fall pulse_cnt", int'(pulse_cnt), 1);

        // random runs with occasional clears
        repeat (120) begin
            @(negedge clock);
            in      = 1'($urandom_range(0, 1));
            clr_cnt = ($urandom_range(0, 15) == 0);
            repeat ($urandom_range(0, 6)) @(negedge clock);
        end
        clr_cnt = 1'b0;
        in      = 1'b0;
        repeat (8) @(negedge clock);

        // saturation
        repeat (260) begin
            in = 1'b1;
            repeat (7) @(negedge clock);
            in = 1'b0;
            repeat (7) @(negedge clock);
        end
        check("saturate pulse_cnt", int'(pulse_cnt), 255);
        clr_cnt = 1'b1;
        @(negedge clock); clr_cnt = 1'b0;
        check("clear pulse_cnt", int'(pulse_cnt), 0);

        // clear on the same edge as a rise
        @(negedge clock); in = 1'b1;
        repeat (6) @(negedge clock);
        clr_cnt = 1'b1;
        @(negedge clock); clr_cnt = 1'b0;
        check("clr+rise rise", int'(rise), 1);
        check("clr+rise pulse_cnt", int'(pulse_cnt), 1);

        // reset in the middle of a high candidate
        @(negedge clock); in = 1'b0;
        repeat (8) @(negedge clock);
        in = 1'b1;
        repeat (3) @(negedge clock);
        #2 reset_n = 1'b0;
        #1 check_all_zero("mid-chk reset");
        in = 1'b0;
        @(negedge clock); #2 reset_n = 1'b1;
        repeat (12) @(negedge clock);
        check("post-reset filt_out", int'(filt_out), 0);
        check("post-reset pulse_cnt", int'(pulse_cnt), 0);

        // release reset with the input already high
        #2 reset_n = 1'b0; in = 1'b1;
        @(negedge clock); #2 reset_n = 1'b1;
        repeat (10) @(negedge clock);
        check("release-high filt_out", int'(filt_out), 1);
        check("release-high pulse_cnt", int'(pulse_cnt), 1);

        repeat (4) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
